// File: rtl/chip8_vga_scanout_if.sv
// Scanout link: pixel enable and framebuffer into the scanout, VGA timing and video out of it.
interface chip8_vga_scanout_if;
    logic          pix_ce;
    logic [2047:0] display_in;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          pixel_on;
    logic          frame_start;
    logic          vblank;

    modport master (
        input  pix_ce,
        input  display_in,
        output hsync,
        output vsync,
        output de,
        output pixel_on,
        output frame_start,
        output vblank
    );

    modport slave (
        output pix_ce,
        output display_in,
        input  hsync,
        input  vsync,
        input  de,
        input  pixel_on,
        input  frame_start,
        input  vblank
    );
endinterface

// File: rtl/chip8_vga_scanout.sv
// CHIP-8 64x32 framebuffer to 640x480@60 VGA raster, 10x scaled, vertically centred.
// Define CHIP8_SCANOUT_FRAME_LATCH_EN to scan from a per-frame snapshot instead of the live framebuffer.
module chip8_vga_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SCALE    = 10,
    parameter int unsigned V_OFFSET = 80
) (
    input  logic                  clk,
    input  logic                  reset,
    chip8_vga_scanout_if.master   vga
);

    localparam logic [9:0] H_ACT_C        = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_C       = 10'(H_ACTIVE + 159);
    localparam logic [9:0] H_SYNC_START_C = 10'(H_ACTIVE + 16);
    localparam logic [9:0] H_SYNC_END_C   = 10'(H_ACTIVE + 111);
    localparam logic [9:0] V_ACT_C        = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_C       = 10'(V_ACTIVE + 44);
    localparam logic [9:0] V_SYNC_START_C = 10'(V_ACTIVE + 10);
    localparam logic [9:0] V_SYNC_END_C   = 10'(V_ACTIVE + 11);
    localparam logic [9:0] V_OFF_C        = 10'(V_OFFSET);
    localparam logic [9:0] V_IMG_END_C    = 10'(V_OFFSET + 32 * SCALE);
    localparam logic [3:0] SCALE_M1_C     = 4'(SCALE - 1);
    localparam logic [4:0] PY_MAX_C       = 5'd31;

    logic [9:0]    h_cnt_r;
    logic [9:0]    v_cnt_r;
    logic [3:0]    sub_x_r;
    logic [5:0]    px_r;
    logic [3:0]    sub_y_r;
    logic [4:0]    py_r;

    logic [9:0]    h_cnt_s;
    logic [9:0]    v_cnt_s;
    logic [3:0]    sub_x_s;
    logic [5:0]    px_s;
    logic [3:0]    sub_y_s;
    logic [4:0]    py_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          v_img_s;

    logic          hsync_s;
    logic          vsync_s;
    logic          de_s;
    logic          pixel_on_s;
    logic          frame_start_s;
    logic          vblank_s;
    logic          window_s;
    logic [2047:0] fb_s;

    logic          hsync_r;
    logic          vsync_r;
    logic          de_r;
    logic          pixel_on_r;
    logic          frame_start_r;
    logic          vblank_r;

`ifdef CHIP8_SCANOUT_FRAME_LATCH_EN
    logic [2047:0] snapshot_r;

    // Capture the framebuffer once per frame at the top of vertical blanking
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot_r <= '0;
        end else if (vga.pix_ce && (h_cnt_r == 10'd0) && (v_cnt_r == V_ACT_C)) begin
            snapshot_r <= vga.display_in;
        end else begin
            snapshot_r <= snapshot_r;
        end
    end

    assign fb_s = snapshot_r;
`else
    assign fb_s = vga.display_in;
`endif

    // Raster and scaling counters: divider-free tracking of the source pixel under the beam
    always_comb begin
        h_wrap_s = (h_cnt_r == H_LAST_C);
        v_wrap_s = (v_cnt_r == V_LAST_C);
        v_img_s  = (v_cnt_r >= V_OFF_C) && (v_cnt_r < V_IMG_END_C);
        h_cnt_s  = h_cnt_r + 10'd1;
        v_cnt_s  = v_cnt_r;
        sub_x_s  = sub_x_r + 4'd1;
        px_s     = px_r;
        sub_y_s  = sub_y_r;
        py_s     = py_r;

        if (h_wrap_s) begin
            h_cnt_s = 10'd0;
            sub_x_s = 4'd0;
            px_s    = 6'd0;
            if (v_wrap_s) begin
                v_cnt_s = 10'd0;
            end else begin
                v_cnt_s = v_cnt_r + 10'd1;
            end
        end else if (sub_x_r == SCALE_M1_C) begin
            sub_x_s = 4'd0;
            px_s    = px_r + 6'd1;
        end else begin
            sub_x_s = sub_x_r + 4'd1;
            px_s    = px_r;
        end

        // Row tracking restarts on entry to the image and freezes outside it
        if (h_wrap_s && (v_cnt_s == V_OFF_C)) begin
            sub_y_s = 4'd0;
            py_s    = 5'd0;
        end else if (h_wrap_s && v_img_s) begin
            if (sub_y_r == SCALE_M1_C) begin
                sub_y_s = 4'd0;
                if (py_r != PY_MAX_C) begin
                    py_s = py_r + 5'd1;
                end else begin
                    py_s = py_r;
                end
            end else begin
                sub_y_s = sub_y_r + 4'd1;
                py_s    = py_r;
            end
        end else begin
            sub_y_s = sub_y_r;
            py_s    = py_r;
        end
    end

    // Output decode from the counter state currently held
    always_comb begin
        window_s      = (h_cnt_r < H_ACT_C) && v_img_s;
        hsync_s       = !((h_cnt_r >= H_SYNC_START_C) && (h_cnt_r <= H_SYNC_END_C));
        vsync_s       = !((v_cnt_r >= V_SYNC_START_C) && (v_cnt_r <= V_SYNC_END_C));
        de_s          = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        vblank_s      = (v_cnt_r >= V_ACT_C);
        frame_start_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        pixel_on_s    = window_s & fb_s[{py_r, px_r}];
    end

    // Counter state register, advancing on the pixel enable
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
            sub_x_r <= 4'd0;
            px_r    <= 6'd0;
            sub_y_r <= 4'd0;
            py_r    <= 5'd0;
        end else if (vga.pix_ce) begin
            h_cnt_r <= h_cnt_s;
            v_cnt_r <= v_cnt_s;
            sub_x_r <= sub_x_s;
            px_r    <= px_s;
            sub_y_r <= sub_y_s;
            py_r    <= py_s;
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
            sub_x_r <= sub_x_r;
            px_r    <= px_r;
            sub_y_r <= sub_y_r;
            py_r    <= py_r;
        end
    end

    // Output registers; frame_start is a single-clk pulse even when pix_ce stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            de_r          <= 1'b0;
            pixel_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
            vblank_r      <= 1'b0;
        end else if (vga.pix_ce) begin
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            de_r          <= de_s;
            pixel_on_r    <= pixel_on_s;
            frame_start_r <= frame_start_s;
            vblank_r      <= vblank_s;
        end else begin
            hsync_r       <= hsync_r;
            vsync_r       <= vsync_r;
            de_r          <= de_r;
            pixel_on_r    <= pixel_on_r;
            frame_start_r <= 1'b0;
            vblank_r      <= vblank_r;
        end
    end

    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.de          = de_r;
    assign vga.pixel_on    = pixel_on_r;
    assign vga.frame_start = frame_start_r;
    assign vga.vblank      = vblank_r;

endmodule
